// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, sample type and pooling FSM states for conv_maxpool.
package conv_pkg;
  localparam int DATA_W = 16;
  localparam int MAX_SIZE = 15;
  localparam int BUF_DEPTH = MAX_SIZE / 2;
  localparam int IDX_W = $clog2(BUF_DEPTH);
  typedef logic signed [DATA_W-1:0] feat_t;
  typedef enum logic {IDLE, STREAM} pool_state_t;
  function automatic feat_t smax(feat_t a, feat_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/conv_pool_linebuf.sv
// conv_pool_linebuf: pair-result line buffer, one write and one read port, async clear.
module conv_pool_linebuf import conv_pkg::*; #(
  parameter int W = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [W-1:0] mem_d [BUF_DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (we && waddr < IDX_W'(BUF_DEPTH)) mem_d[waddr] = wdata;
  end
  assign rdata = (raddr < IDX_W'(BUF_DEPTH)) ? mem_q[raddr] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    else mem_q <= mem_d;
endmodule

// File: rtl/conv_maxpool.sv
// conv_maxpool: 2x2 stride-2 pooling of a raster N x N signed feature map.
// Define CONV_POOL_AVG_EN to add the pool_mode input (1 = average pooling).
module conv_maxpool import conv_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic [3:0]        map_size,
`ifdef CONV_POOL_AVG_EN
  input  logic              pool_mode,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
`ifdef CONV_POOL_AVG_EN
  localparam int BUF_W = DATA_W + 1;
`else
  localparam int BUF_W = DATA_W;
`endif
  pool_state_t state_q, state_d;
  logic [3:0] n_q, n_d, row_q, row_d, col_q, col_d, p2;
  feat_t hold_q, hold_d, out_data_q, out_data_d, pair_max, res;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, last_col, last_row, buf_we;
  logic [BUF_W-1:0] pair_val, buf_rdata;
  assign p2 = {n_q[3:1], 1'b0};
  assign last_col = col_q == n_q - 4'd1;
  assign last_row = row_q == n_q - 4'd1;
  assign pair_max = smax(hold_q, in_data);
`ifdef CONV_POOL_AVG_EN
  logic mode_q, mode_d;
  logic signed [DATA_W:0] pair_sum;
  logic signed [DATA_W+1:0] quad;
  assign pair_sum = {hold_q[DATA_W-1], hold_q} + {in_data[DATA_W-1], in_data};
  assign quad = {buf_rdata[BUF_W-1], buf_rdata} + {pair_sum[DATA_W], pair_sum};
  assign pair_val = mode_q ? pair_sum : {pair_max[DATA_W-1], pair_max};
  assign res = mode_q ? quad[DATA_W+1:2] : smax(buf_rdata[DATA_W-1:0], pair_max);
`else
  assign pair_val = pair_max;
  assign res = smax(buf_rdata, pair_max);
`endif
  conv_pool_linebuf #(.W(BUF_W)) u_buf (
    .clk(clk), .rst_n(rst_n), .we(buf_we), .waddr(col_q[3:1]), .wdata(pair_val),
    .raddr(col_q[3:1]), .rdata(buf_rdata)
  );
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    row_d = row_q;
    col_d = col_q;
    hold_d = hold_q;
    out_valid_d = 1'b0;
    out_data_d = out_data_q;
    out_last_d = 1'b0;
    buf_we = 1'b0;
`ifdef CONV_POOL_AVG_EN
    mode_d = mode_q;
`endif
    if (state_q == IDLE) begin
      if (cfg_valid && map_size >= 4'd2) begin
        state_d = STREAM;
        n_d = map_size;
        row_d = '0;
        col_d = '0;
`ifdef CONV_POOL_AVG_EN
        mode_d = pool_mode;
`endif
      end
    end else if (in_valid) begin
      col_d = last_col ? 4'd0 : col_q + 4'd1;
      row_d = last_col ? row_q + 4'd1 : row_q;
      if (last_col && last_row) begin
        state_d = IDLE;
        row_d = '0;
      end
      if (!col_q[0] && col_q < p2) hold_d = in_data;
      // Odd columns complete a pair; even rows stash it, odd rows finish the window.
      if (col_q[0] && row_q < p2) begin
        buf_we = !row_q[0];
        out_valid_d = row_q[0];
        out_data_d = row_q[0] ? res : out_data_q;
        out_last_d = row_q[0] && row_q == p2 - 4'd1 && col_q == p2 - 4'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      n_q <= '0;
      row_q <= '0;
      col_q <= '0;
      hold_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
`ifdef CONV_POOL_AVG_EN
      mode_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      row_q <= row_d;
      col_q <= col_d;
      hold_q <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
`ifdef CONV_POOL_AVG_EN
      mode_q <= mode_d;
`endif
    end
  assign busy = state_q == STREAM;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
endmodule
